// File: rtl/seg_display_ctrl.sv
// Registered NDIG-digit 7-segment driver: hex or decimal (serial double-dabble) with LZ blanking and overflow.
// Optional blink gating is enabled by defining SEG_DISPLAY_CTRL_BLINK_EN.
module seg_display_ctrl #(
   parameter int NDIG     = 6,
   parameter int WIDTH    = 20,
   parameter int LZ_BLANK = 1
`ifdef SEG_DISPLAY_CTRL_BLINK_EN
   , parameter int BLINK_DIV = 25_000_000
`endif
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [WIDTH-1:0]  VALUE,
   input  logic              LOAD,
   input  logic              DEC_MODE,
   input  logic [NDIG-1:0]   DP,
`ifdef SEG_DISPLAY_CTRL_BLINK_EN
   input  logic              BLINK,
`endif
   output logic              BUSY,
   output logic [8*NDIG-1:0] HEX_OUT,
   output logic [1:0]        DBG_STATE
);

   // Handshake: LOAD is a request sampled only while BUSY=0; BUSY=1 from the capture
   // edge until the edge that registers the new display. Requests while busy are dropped.

   localparam int BW = 4 * (NDIG + 1);
   localparam int CW = $clog2(WIDTH + 1);
   localparam int EW = 4 * NDIG + WIDTH;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SHIFT  = 2'd1,
      S_FORMAT = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [WIDTH-1:0]    val_q, val_d;
   logic                dec_q, dec_d;
   logic [NDIG-1:0]     dp_q, dp_d;
   logic [BW-1:0]       bcd_q, bcd_d;
   logic                ovf_q, ovf_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [8*NDIG-1:0]   hex_q, hex_d;
   logic [BW-1:0]       adj;
   logic [EW-1:0]       ext;
   logic [8*NDIG-1:0]   fmt;
   logic                ovf;
   logic                lead;
   logic [3:0]          nib;

   function automatic logic [6:0] seg7(input logic [3:0] n);
      case (n)
         4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;  4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
         4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;  4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
         4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;  4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
         4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;  4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
      endcase
   endfunction

   always_comb begin
      adj = bcd_q;
      for (int n = 0; n < NDIG + 1; n++) begin
         if (bcd_q[4*n +: 4] >= 4'd5) adj[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
      end
   end

   assign ext = {{(4*NDIG){1'b0}}, val_q};

   // A bit pushed out of the top BCD nibble is sticky overflow, so narrow NDIG never wraps.
   always_comb begin
      fmt  = '1;
      lead = 1'b1;
      nib  = 4'd0;
      if (dec_q) ovf = ovf_q | (bcd_q[BW-1 -: 4] != 4'd0);
      else       ovf = ((ext >> (4*NDIG)) != '0);
      for (int i = NDIG - 1; i >= 0; i--) begin
         nib  = dec_q ? bcd_q[4*i +: 4] : ext[4*i +: 4];
         lead = lead & (nib == 4'd0) & ~dp_q[i];
         if (ovf)                                 fmt[8*i +: 8] = 8'hBF;
         else if (LZ_BLANK != 0 && lead && i != 0) fmt[8*i +: 8] = {~dp_q[i], 7'h7F};
         else                                     fmt[8*i +: 8] = {~dp_q[i], seg7(nib)};
      end
   end

   always_comb begin
      state_d = state_q;
      val_d   = val_q;
      dec_d   = dec_q;
      dp_d    = dp_q;
      bcd_d   = bcd_q;
      ovf_d   = ovf_q;
      cnt_d   = cnt_q;
      hex_d   = hex_q;
      case (state_q)
         S_IDLE: begin
            if (LOAD) begin
               val_d   = VALUE;
               dec_d   = DEC_MODE;
               dp_d    = DP;
               bcd_d   = '0;
               ovf_d   = 1'b0;
               cnt_d   = '0;
               state_d = DEC_MODE ? S_SHIFT : S_FORMAT;
            end
         end
         S_SHIFT: begin
            bcd_d = {adj[BW-2:0], val_q[WIDTH-1]};
            val_d = val_q << 1;
            ovf_d = ovf_q | adj[BW-1];
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) state_d = S_FORMAT;
         end
         S_FORMAT: begin
            hex_d   = fmt;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
         val_q   <= '0;
         dec_q   <= 1'b0;
         dp_q    <= '0;
         bcd_q   <= '0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
         hex_q   <= '1;
      end else begin
         state_q <= state_d;
         val_q   <= val_d;
         dec_q   <= dec_d;
         dp_q    <= dp_d;
         bcd_q   <= bcd_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
         hex_q   <= hex_d;
      end
   end

   assign BUSY      = (state_q != S_IDLE);
   assign DBG_STATE = state_q;

`ifdef SEG_DISPLAY_CTRL_BLINK_EN
   localparam int DW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   logic [DW-1:0] div_q;
   logic          phase_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         div_q   <= '0;
         phase_q <= 1'b1;
      end else if (div_q == DW'(BLINK_DIV - 1)) begin
         div_q   <= '0;
         phase_q <= ~phase_q;
      end else begin
         div_q   <= div_q + 1'b1;
      end
   end

   // Blanking is applied after the register so the held display survives the off phase.
   assign HEX_OUT = (BLINK && !phase_q) ? '1 : hex_q;
`else
   assign HEX_OUT = hex_q;
`endif

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Self-checking bench for seg_display_ctrl: directed cases plus randomized loads against a digit-arithmetic model.
module tb_seg_display_ctrl;

   localparam int NDIG  = 6;
   localparam int WIDTH = 20;

   logic              CLK;
   logic              RST;
   logic [WIDTH-1:0]  VALUE;
   logic              LOAD;
   logic              DEC_MODE;
   logic [NDIG-1:0]   DP;
   logic              BUSY;
   logic [8*NDIG-1:0] HEX_OUT;
   logic [1:0]        dbg_state;
`ifdef SEG_DISPLAY_CTRL_BLINK_EN
   logic              BLINK;
`endif

   int n_vec = 0;
   int n_err = 0;
   logic [8*NDIG-1:0] exp_q[$];
   logic [8*NDIG-1:0] cur_disp;

`ifdef SEG_DISPLAY_CTRL_BLINK_EN
   seg_display_ctrl #(.NDIG(NDIG), .WIDTH(WIDTH), .LZ_BLANK(1), .BLINK_DIV(4)) dut (
      .CLK(CLK), .RST(RST), .VALUE(VALUE), .LOAD(LOAD), .DEC_MODE(DEC_MODE), .DP(DP),
      .BLINK(BLINK), .BUSY(BUSY), .HEX_OUT(HEX_OUT), .DBG_STATE(dbg_state));
`else
   seg_display_ctrl #(.NDIG(NDIG), .WIDTH(WIDTH), .LZ_BLANK(1)) dut (
      .CLK(CLK), .RST(RST), .VALUE(VALUE), .LOAD(LOAD), .DEC_MODE(DEC_MODE), .DP(DP),
      .BUSY(BUSY), .HEX_OUT(HEX_OUT), .DBG_STATE(dbg_state));
`endif

   // ---------------- clock / reset ----------------
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic apply_reset();
      RST  = 1'b1;
      LOAD = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b0;
      cur_disp = '1;
      exp_q.delete();
   endtask

   // ---------------- reference model ----------------
   function automatic logic [7:0] seg_byte(input int unsigned d);
      case (d)
         0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
         4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
         8: return 8'h80;  9: return 8'h90;  10: return 8'h88; 11: return 8'h83;
         12: return 8'hC6; 13: return 8'hA1; 14: return 8'h86; default: return 8'h8E;
      endcase
   endfunction

   function automatic logic [8*NDIG-1:0] model(input longint unsigned v, input bit dec,
                                               input logic [NDIG-1:0] dp);
      logic [8*NDIG-1:0] r;
      int unsigned       dig [NDIG];
      longint unsigned   x;
      longint unsigned   base;
      bit                lead;
      x    = v;
      base = dec ? 10 : 16;
      r    = '1;
      for (int i = 0; i < NDIG; i++) begin
         dig[i] = int'(x % base);
         x      = x / base;
      end
      if (x != 0) return {NDIG{8'hBF}};
      lead = 1'b1;
      for (int i = NDIG - 1; i >= 0; i--) begin
         lead = lead && (dig[i] == 0) && !dp[i];
         if (lead && i > 0) r[8*i +: 8] = 8'hFF;
         else               r[8*i +: 8] = seg_byte(dig[i]) & (dp[i] ? 8'h7F : 8'hFF);
      end
      return r;
   endfunction

   // ---------------- driver ----------------
   task automatic run_load(input logic [WIDTH-1:0] v, input bit dec,
                           input logic [NDIG-1:0] dp, input string tag);
      logic [8*NDIG-1:0] exp;
      int                cyc;
      int                lat;
      bit                held;
      exp_q.push_back(model(longint'(v), dec, dp));
      lat      = dec ? WIDTH + 1 : 1;
      VALUE    = v;
      DEC_MODE = dec;
      DP       = dp;
      LOAD     = 1'b1;
      @(posedge CLK);
      #1;
      LOAD     = 1'b0;
      VALUE    = WIDTH'($urandom);
      DEC_MODE = 1'($urandom);
      DP       = NDIG'($urandom);
      cyc  = 0;
      held = 1'b1;
      while (BUSY && cyc < 200) begin
         if (HEX_OUT !== cur_disp) held = 1'b0;
         @(posedge CLK);
         #1;
         cyc++;
      end
      exp = exp_q.pop_front();
      n_vec++;
      if (cyc !== lat) begin
         n_err++;
         $display("FAIL %s latency: got %0d cycles, expected %0d", tag, cyc, lat);
      end
      n_vec++;
      if (!held) begin
         n_err++;
         $display("FAIL %s hold: display changed during conversion, expected %h", tag, cur_disp);
      end
      n_vec++;
      if (HEX_OUT !== exp) begin
         n_err++;
         $display("FAIL %s hex_out: got %h expected %h (v=%0d dec=%0b dp=%b)", tag, HEX_OUT, exp, v, dec, dp);
      end
      cur_disp = exp;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      apply_reset();
      n_vec++;
      if (HEX_OUT !== {NDIG{8'hFF}}) begin
         n_err++;
         $display("FAIL reset_hex: got %h expected %h", HEX_OUT, {NDIG{8'hFF}});
      end
      n_vec++;
      if (BUSY !== 1'b0) begin
         n_err++;
         $display("FAIL reset_busy: got %b expected 0", BUSY);
      end
      n_vec++;
      if (dbg_state !== 2'd0) begin
         n_err++;
         $display("FAIL reset_state: got %0d expected 0 (idle)", dbg_state);
      end
   endtask

   task automatic test_hex();
      run_load(20'hABCDE, 1'b0, 6'b0, "hex_abcde");
      n_vec++;
      if (HEX_OUT !== 48'hFF_88_83_C6_A1_86) begin
         n_err++;
         $display("FAIL hex_abcde_const: got %h expected %h", HEX_OUT, 48'hFF_88_83_C6_A1_86);
      end
   endtask

   task automatic test_decimal();
      run_load(20'd42, 1'b1, 6'b0, "dec_42");
      n_vec++;
      if (HEX_OUT !== 48'hFF_FF_FF_FF_99_A4) begin
         n_err++;
         $display("FAIL dec_42_const: got %h expected %h", HEX_OUT, 48'hFF_FF_FF_FF_99_A4);
      end
      run_load(20'd42, 1'b1, 6'b000100, "dec_42_dp");
      n_vec++;
      if (HEX_OUT !== 48'hFF_FF_FF_40_99_A4) begin
         n_err++;
         $display("FAIL dec_42_dp_const: got %h expected %h", HEX_OUT, 48'hFF_FF_FF_40_99_A4);
      end
   endtask

   task automatic test_overflow();
      run_load(20'd1000000, 1'b1, 6'b0, "dec_ovf");
      n_vec++;
      if (HEX_OUT !== {NDIG{8'hBF}}) begin
         n_err++;
         $display("FAIL dec_ovf_const: got %h expected %h", HEX_OUT, {NDIG{8'hBF}});
      end
      run_load(20'd999999, 1'b1, 6'b101010, "dec_max");
      run_load(20'd999999, 1'b1, 6'b0, "dec_max_nodp");
      n_vec++;
      if (HEX_OUT !== {NDIG{8'h90}}) begin
         n_err++;
         $display("FAIL dec_max_const: got %h expected %h", HEX_OUT, {NDIG{8'h90}});
      end
   endtask

   task automatic test_handshake();
      int cyc;
      VALUE    = 20'd123456;
      DEC_MODE = 1'b1;
      DP       = '0;
      LOAD     = 1'b1;
      @(posedge CLK);
      #1;
      LOAD = 1'b0;
      repeat (5) @(posedge CLK);
      #1;
      VALUE    = 20'd7;
      DEC_MODE = 1'b0;
      LOAD     = 1'b1;
      @(posedge CLK);
      #1;
      LOAD = 1'b0;
      cyc  = 6;
      while (BUSY && cyc < 200) begin
         @(posedge CLK);
         #1;
         cyc++;
      end
      n_vec++;
      if (cyc !== WIDTH + 1) begin
         n_err++;
         $display("FAIL hs_latency: got %0d cycles, expected %0d", cyc, WIDTH + 1);
      end
      n_vec++;
      if (HEX_OUT !== 48'hF9_A4_B0_99_92_82) begin
         n_err++;
         $display("FAIL hs_display: got %h expected %h", HEX_OUT, 48'hF9_A4_B0_99_92_82);
      end
      cur_disp = 48'hF9_A4_B0_99_92_82;
      @(posedge CLK);
      #1;
      n_vec++;
      if (BUSY !== 1'b0) begin
         n_err++;
         $display("FAIL hs_no_queue: got busy=%b expected 0", BUSY);
      end
   endtask

   task automatic test_abort();
      bit ok;
      apply_reset();
      VALUE    = 20'd987654;
      DEC_MODE = 1'b1;
      DP       = 6'b111111;
      LOAD     = 1'b1;
      @(posedge CLK);
      #1;
      LOAD = 1'b0;
      repeat (10) @(posedge CLK);
      #1;
      RST = 1'b1;
      @(posedge CLK);
      #1;
      RST = 1'b0;
      n_vec++;
      if (HEX_OUT !== {NDIG{8'hFF}} || BUSY !== 1'b0) begin
         n_err++;
         $display("FAIL abort_now: got hex=%h busy=%b expected hex=%h busy=0", HEX_OUT, BUSY, {NDIG{8'hFF}});
      end
      ok = 1'b1;
      repeat (WIDTH + 5) begin
         @(posedge CLK);
         #1;
         if (HEX_OUT !== {NDIG{8'hFF}} || BUSY !== 1'b0) ok = 1'b0;
      end
      n_vec++;
      if (!ok) begin
         n_err++;
         $display("FAIL abort_later: got hex=%h busy=%b expected hex=%h busy=0", HEX_OUT, BUSY, {NDIG{8'hFF}});
      end
      cur_disp = '1;
   endtask

   task automatic test_back_to_back();
      logic [8*NDIG-1:0] e1, e2;
      e1 = model(longint'(20'h12345), 1'b0, 6'b0);
      e2 = model(longint'(20'h00F0A), 1'b0, 6'b000010);
      VALUE    = 20'h12345;
      DEC_MODE = 1'b0;
      DP       = '0;
      LOAD     = 1'b1;
      @(posedge CLK);
      #1;
      VALUE = 20'h00F0A;
      DP    = 6'b000010;
      @(posedge CLK);
      #1;
      n_vec++;
      if (HEX_OUT !== e1 || BUSY !== 1'b0) begin
         n_err++;
         $display("FAIL b2b_first: got hex=%h busy=%b expected hex=%h busy=0", HEX_OUT, BUSY, e1);
      end
      @(posedge CLK);
      #1;
      LOAD = 1'b0;
      n_vec++;
      if (BUSY !== 1'b1) begin
         n_err++;
         $display("FAIL b2b_recapture: got busy=%b expected 1", BUSY);
      end
      @(posedge CLK);
      #1;
      n_vec++;
      if (HEX_OUT !== e2 || BUSY !== 1'b0) begin
         n_err++;
         $display("FAIL b2b_second: got hex=%h busy=%b expected hex=%h busy=0", HEX_OUT, BUSY, e2);
      end
      cur_disp = e2;
   endtask

   task automatic test_random();
      logic [WIDTH-1:0] v;
      logic [NDIG-1:0]  dp;
      bit               dec;
      for (int k = 0; k < 40; k++) begin
         case ($urandom_range(0, 3))
            0:       v = WIDTH'($urandom_range(0, 99));
            1:       v = WIDTH'($urandom_range(999990, 1000010));
            default: v = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
         endcase
         dec = 1'($urandom_range(0, 1));
         dp  = ($urandom_range(0, 2) == 0) ? NDIG'($urandom) : '0;
         run_load(v, dec, dp, "rand");
      end
   endtask

`ifdef SEG_DISPLAY_CTRL_BLINK_EN
   task automatic test_blink();
      logic [8*NDIG-1:0] s [16];
      logic [8*NDIG-1:0] on_word;
      bit                ok;
      int                trans;
      on_word = 48'hFF_FF_FF_FF_FF_C0;
      run_load(20'd0, 1'b0, 6'b0, "blink_load");
      BLINK = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(posedge CLK);
         #1;
         s[i] = HEX_OUT;
      end
      ok    = 1'b1;
      trans = 0;
      for (int i = 0; i < 16; i++) begin
         if (s[i] !== on_word && s[i] !== {NDIG{8'hFF}}) ok = 1'b0;
         if (i >= 4 && s[i] === s[i-4]) ok = 1'b0;
         if (i >= 1 && s[i] !== s[i-1]) trans++;
      end
      n_vec++;
      if (!ok || trans < 3 || trans > 4) begin
         n_err++;
         $display("FAIL blink_on: got %0d transitions, last %h; expected runs of 4 between %h and all-FF", trans, s[15], on_word);
      end
      BLINK = 1'b0;
      ok    = 1'b1;
      repeat (10) begin
         @(posedge CLK);
         #1;
         if (HEX_OUT !== on_word) ok = 1'b0;
      end
      n_vec++;
      if (!ok) begin
         n_err++;
         $display("FAIL blink_off: got %h expected steady %h", HEX_OUT, on_word);
      end
   endtask
`endif

   // ---------------- sequence and report ----------------
   initial begin
      RST      = 1'b1;
      LOAD     = 1'b0;
      VALUE    = '0;
      DEC_MODE = 1'b0;
      DP       = '0;
      cur_disp = '1;
`ifdef SEG_DISPLAY_CTRL_BLINK_EN
      BLINK    = 1'b0;
`endif
      test_reset();
      test_hex();
      test_decimal();
      test_overflow();
      test_handshake();
      test_abort();
      test_back_to_back();
      test_random();
`ifdef SEG_DISPLAY_CTRL_BLINK_EN
      test_blink();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
